riscv_dp_decode_stage: RTL and testbench
========================================

// Module: riscv_dp_decode_stage
// PURPOSE
//  IF/ID pipeline stage with a 2-entry skid buffer. Accepts fetched instructions
//  over a valid/ready handshake and registers them. Pre-decodes the opcode into the
//  3-bit immediate-source select, then presents instr[31:7] and that select to the
//  immediate extender and decode logic directly downstream.
//  Absorbs one cycle of downstream backpressure without dropping data.
// PARAMETERS
//  XLEN   32   width of the PC carried alongside each instruction
// PORTS
//  iclk       in   1       clock; all state updates on rising edge
//  irst       in   1       reset, asynchronous, active-high
//  ivalid     in   1       upstream instruction valid
//  oready     out  1       stage can accept (transfer when ivalid & oready)
//  iinstr     in   32      fetched instruction word
//  ipc        in   XLEN    PC of iinstr
//  iflush     in   1       synchronous flush (taken branch/jump redirect)
//  ovalid     out  1       head entry valid to downstream
//  iready     in   1       downstream accepts (consume when ovalid & iready)
//  oinstr     out  25      head instr[31:7], to the extender's instruction input
//  oimm_src   out  3       head immediate-source select, to the extender's select input
//  opc        out  XLEN    head PC
//  oillegal   out  1       head opcode is not a supported RV32I opcode
// BEHAVIOUR
//  - Reset (async, irst=1): state EMPTY; ovalid=0; oinstr=0; oimm_src=3'b000;
//    opc=0; oillegal=0; oready=1 (EMPTY is never full).
//  - oready = (state != FULL). It depends on registered state only, with no
//    combinational path from iready.
//  - push = ivalid & oready & ~iflush. pop = ovalid & iready.
//  - States and transitions (count of held entries):
//    EMPTY: push -> ONE (head <= input).
//    ONE:   push & pop -> ONE (head <= input)
//           push & ~pop -> FULL (skid <= input)
//           pop & ~push -> EMPTY
//           otherwise hold.
//    FULL:  pop -> ONE (head <= skid); otherwise hold. No push is possible.
//  - Latency: an instruction accepted in cycle N is on the outputs with ovalid=1
//    in cycle N+1.
//  - While ovalid & ~iready, oinstr/oimm_src/opc/oillegal stay stable.
//  - Order is strictly preserved; the skid entry never overtakes the head.
//  - iflush=1: next state EMPTY and ovalid=0 next cycle, whatever the current
//    ivalid/iready. An input offered in the flush cycle is not accepted.
//    A pop in the same cycle still counts as consumed downstream.
//  - Pre-decode uses opcode = instr[6:0] and is computed at push. It is stored
//    with the entry, so oimm_src is registered:
//    0000011 / 0010011 / 1100111 (load, op-imm, jalr)  -> 000 (I)
//    0100011 (store)                                   -> 001 (S)
//    1100011 (branch)                                  -> 010 (B)
//    1101111 (jal)                                     -> 011 (J)
//    0110111 / 0010111 (lui, auipc)                    -> 100 (U)
//    0110011 (op, R-type)    -> 000, oillegal=0 (immediate unused)
//    0001111 / 1110011 (fence, system) -> 000, oillegal=0
//    any other opcode        -> 000, oillegal=1
//  - instr[1:0] != 2'b11 is always oillegal=1.
//  - Data registers are not cleared on flush or pop; only valid state is cleared.
//    Output data is don't-care while ovalid=0.
//  - Reset asserted mid-operation discards all entries immediately (async).
//  - Outputs return to reset values until the first rising edge after irst falls.
// TESTING
//  1. Reset then push 0x00500093 (addi x1,x0,5), iready=1 -> next cycle ovalid=1,
//     oinstr=0x00500093>>7, oimm_src=000, oillegal=0; cycle after: ovalid=0.
//  2. Stream 0x00112223 (sw), 0x00208463 (beq), 0x008000EF (jal),
//     0x123450B7 (lui) back-to-back with iready=1 -> oimm_src 001,010,011,100
//     on consecutive cycles; oready stays 1.
//  3. Hold iready=0, push A then B -> oready=0 after B, outputs show A stably.
//     Raise iready -> A then B delivered in order; oready=1 once ONE.
//  4. State FULL, assert iflush with ivalid=1 -> next cycle ovalid=0, oready=1,
//     input not accepted; the following push is delivered normally.
//  5. Push 0x0000007F (bad opcode) and 0x00000013 with instr[1:0]=00
//     (0x00000010) -> oillegal=1, oimm_src=000 for both.
//  6. Assert irst asynchronously between edges while in FULL -> ovalid falls
//     immediately, outputs zero; after release, first push behaves as in test 1.

Source files
------------

// File: rtl/riscv_dp_decode_stage.sv
// IF/ID stage: 2-entry skid buffer with opcode pre-decode to immediate-source select.
// Latency: an instruction accepted in cycle N is presented in cycle N+1.
// Backpressure: absorbs one stalled cycle in the skid entry; oready comes from registered state only.
module riscv_dp_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            iclk,
    input  logic            irst,
    input  logic            ivalid,
    output logic            oready,
    input  logic [31:0]     iinstr,
    input  logic [XLEN-1:0] ipc,
    input  logic            iflush,
    output logic            ovalid,
    input  logic            iready,
    output logic [24:0]     oinstr,
    output logic [2:0]      oimm_src,
    output logic [XLEN-1:0] opc,
    output logic            oillegal
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t          state_q, state_d;

    // Head entry drives the outputs directly; skid entry holds the overflow.
    logic [24:0]     head_instr_q, skid_instr_q;
    logic [2:0]      head_src_q,   skid_src_q;
    logic [XLEN-1:0] head_pc_q,    skid_pc_q;
    logic            head_ill_q,   skid_ill_q;

    logic            push, pop;
    logic            load_head_in, load_head_skid, load_skid;
    logic [2:0]      in_src;
    logic            in_ill;

    assign oready   = (state_q != FULL);
    assign ovalid   = (state_q != EMPTY);
    assign push     = ivalid & oready & ~iflush;
    assign pop      = ovalid & iready;

    assign oinstr   = head_instr_q;
    assign oimm_src = head_src_q;
    assign opc      = head_pc_q;
    assign oillegal = head_ill_q;

    // Pre-decode the incoming opcode; the full 7-bit compare also rejects instr[1:0] != 11.
    always_comb begin
        in_src = 3'b000;
        in_ill = 1'b0;
        case (iinstr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: in_src = 3'b000; // load, op-imm, jalr
            7'b0100011:                         in_src = 3'b001; // store
            7'b1100011:                         in_src = 3'b010; // branch
            7'b1101111:                         in_src = 3'b011; // jal
            7'b0110111, 7'b0010111:             in_src = 3'b100; // lui, auipc
            7'b0110011, 7'b0001111, 7'b1110011: in_src = 3'b000; // op, fence, system
            default:                            in_ill = 1'b1;
        endcase
    end

    // Next occupancy and which entry gets loaded; flush overrides to EMPTY.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (iflush) begin
            state_d = EMPTY;
        end
    end

    // Occupancy and entry registers; data is only overwritten on load, never cleared.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q      <= EMPTY;
            head_instr_q <= '0;
            head_src_q   <= 3'b000;
            head_pc_q    <= '0;
            head_ill_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_src_q   <= 3'b000;
            skid_pc_q    <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_head_in) begin
                head_instr_q <= iinstr[31:7];
                head_src_q   <= in_src;
                head_pc_q    <= ipc;
                head_ill_q   <= in_ill;
            end else if (load_head_skid) begin
                head_instr_q <= skid_instr_q;
                head_src_q   <= skid_src_q;
                head_pc_q    <= skid_pc_q;
                head_ill_q   <= skid_ill_q;
            end
            if (load_skid) begin
                skid_instr_q <= iinstr[31:7];
                skid_src_q   <= in_src;
                skid_pc_q    <= ipc;
                skid_ill_q   <= in_ill;
            end
        end
    end

endmodule

// File: tb/tb_riscv_dp_decode_stage.sv
// Directed bench for the IF/ID skid-buffer stage with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
// Backpressure is exercised by holding iready low and checking stability and order.
module tb_riscv_dp_decode_stage;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic        oready;
    logic [31:0] iinstr;
    logic [31:0] ipc;
    logic        iflush;
    logic        ovalid;
    logic        iready;
    logic [24:0] oinstr;
    logic [2:0]  oimm_src;
    logic [31:0] opc;
    logic        oillegal;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_dp_decode_stage #(.XLEN(32)) dut (
        .iclk     (iclk),
        .irst     (irst),
        .ivalid   (ivalid),
        .oready   (oready),
        .iinstr   (iinstr),
        .ipc      (ipc),
        .iflush   (iflush),
        .ovalid   (ovalid),
        .iready   (iready),
        .oinstr   (oinstr),
        .oimm_src (oimm_src),
        .opc      (opc),
        .oillegal (oillegal)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        ivalid = v;
        iinstr = ins;
        ipc    = pc;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [2:0] src, input logic ill);
        logic [31:0] upper;
        upper = ins >> 7;
        chk({tag, ".ovalid"},   {31'd0, ovalid}, 32'd1);
        chk({tag, ".oinstr"},   {7'd0, oinstr}, upper);
        chk({tag, ".opc"},      opc, pc);
        chk({tag, ".oimm_src"}, {29'd0, oimm_src}, {29'd0, src});
        chk({tag, ".oillegal"}, {31'd0, oillegal}, {31'd0, ill});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".ovalid"},   {31'd0, ovalid}, 32'd0);
        chk({tag, ".oready"},   {31'd0, oready}, 32'd1);
        chk({tag, ".oinstr"},   {7'd0, oinstr}, 32'd0);
        chk({tag, ".oimm_src"}, {29'd0, oimm_src}, 32'd0);
        chk({tag, ".opc"},      opc, 32'd0);
        chk({tag, ".oillegal"}, {31'd0, oillegal}, 32'd0);
    endtask

    logic [31:0] t2_ins [4] = '{32'h00112223, 32'h00208463, 32'h008000EF, 32'h123450B7};
    logic [2:0]  t2_src [4] = '{3'b001, 3'b010, 3'b011, 3'b100};

    logic [31:0] t5_ins [5] = '{32'h0000007F, 32'h00000010, 32'h000080E7, 32'h00000097, 32'h0000000F};
    logic [2:0]  t5_src [5] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    logic        t5_ill [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        irst   = 1'b1;
        iflush = 1'b0;
        iready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        chk_reset_outs("t0_reset");
        @(negedge iclk);
        irst = 1'b0;
        step();
        chk_reset_outs("t0_idle");

        // Test 1: single addi, one-cycle latency, then drains.
        iready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h00000100);
        step();
        chk_head("t1", 32'h00500093, 32'h00000100, 3'b000, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t1.drain_ovalid", {31'd0, ovalid}, 32'd0);

        // Test 2: back-to-back stream of S/B/J/U types.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t2_ins[i], 32'h00000200 + 32'(i * 4));
            step();
            chk_head($sformatf("t2[%0d]", i), t2_ins[i], 32'h00000200 + 32'(i * 4), t2_src[i], 1'b0);
            chk($sformatf("t2[%0d].oready", i), {31'd0, oready}, 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t2.drain_ovalid", {31'd0, ovalid}, 32'd0);

        // Test 3: fill under backpressure, then drain in order.
        iready = 1'b0;
        drive(1'b1, 32'h00112223, 32'h00000300);
        step();
        chk_head("t3.A", 32'h00112223, 32'h00000300, 3'b001, 1'b0);
        chk("t3.one_oready", {31'd0, oready}, 32'd1);
        drive(1'b1, 32'h00208463, 32'h00000304);
        step();
        chk_head("t3.A_held", 32'h00112223, 32'h00000300, 3'b001, 1'b0);
        chk("t3.full_oready", {31'd0, oready}, 32'd0);
        drive(1'b1, 32'h0000007F, 32'h00000308);
        step();
        chk_head("t3.A_stable", 32'h00112223, 32'h00000300, 3'b001, 1'b0);
        chk("t3.full_oready2", {31'd0, oready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        iready = 1'b1;
        step();
        chk_head("t3.B", 32'h00208463, 32'h00000304, 3'b010, 1'b0);
        chk("t3.one_again_oready", {31'd0, oready}, 32'd1);
        step();
        chk("t3.drain_ovalid", {31'd0, ovalid}, 32'd0);

        // Test 4: flush from FULL with an input offered; it must not be accepted.
        iready = 1'b0;
        drive(1'b1, 32'h00112223, 32'h00000400);
        step();
        drive(1'b1, 32'h00208463, 32'h00000404);
        step();
        chk("t4.full_oready", {31'd0, oready}, 32'd0);
        iflush = 1'b1;
        drive(1'b1, 32'h008000EF, 32'h00000408);
        step();
        iflush = 1'b0;
        chk("t4.flush_ovalid", {31'd0, ovalid}, 32'd0);
        chk("t4.flush_oready", {31'd0, oready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t4.not_accepted", {31'd0, ovalid}, 32'd0);
        iready = 1'b1;
        drive(1'b1, 32'h123450B7, 32'h00000500);
        step();
        chk_head("t4.after", 32'h123450B7, 32'h00000500, 3'b100, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t4.drain_ovalid", {31'd0, ovalid}, 32'd0);

        // Test 5: illegal opcodes and remaining legal classes.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, t5_ins[i], 32'h00000600 + 32'(i * 4));
            step();
            chk_head($sformatf("t5[%0d]", i), t5_ins[i], 32'h00000600 + 32'(i * 4), t5_src[i], t5_ill[i]);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t5.drain_ovalid", {31'd0, ovalid}, 32'd0);

        // Test 6: async reset mid-cycle while FULL.
        iready = 1'b0;
        drive(1'b1, 32'h00112223, 32'h00000700);
        step();
        drive(1'b1, 32'h00208463, 32'h00000704);
        step();
        drive(1'b0, 32'h0, 32'h0);
        chk("t6.full_oready", {31'd0, oready}, 32'd0);
        #2;
        irst = 1'b1;
        #1;
        chk_reset_outs("t6.async");
        @(negedge iclk);
        irst = 1'b0;
        #1;
        chk_reset_outs("t6.released");
        step();
        chk_reset_outs("t6.first_edge");
        iready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h00000100);
        step();
        chk_head("t6.push", 32'h00500093, 32'h00000100, 3'b000, 1'b0);
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk("t6.drain_ovalid", {31'd0, ovalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
